// File: rtl/ddr_app_arbiter_if.sv
// Bundle of the two requester ports, the read return path and the MIG app_* port.
// The arbiter takes the slave view; whoever drives the requesters and models the MIG takes master.
interface ddr_app_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 512,
  parameter int MASK_W = DATA_W / 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_cmd;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [MASK_W-1:0] req0_wmask;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_cmd;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [MASK_W-1:0] req1_wmask;
  logic              rd0_valid;
  logic              rd1_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport slave (
    input  req0_valid, req0_cmd, req0_addr, req0_wdata, req0_wmask,
    input  req1_valid, req1_cmd, req1_addr, req1_wdata, req1_wmask,
    output req0_ready, req1_ready, rd0_valid, rd1_valid, rd_data,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport master (
    output req0_valid, req0_cmd, req0_addr, req0_wdata, req0_wmask,
    output req1_valid, req1_cmd, req1_addr, req1_wdata, req1_wmask,
    input  req0_ready, req1_ready, rd0_valid, rd1_valid, rd_data,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter sharing one MIG app port between two requesters, with a tag FIFO
// that steers single-beat read returns back to whichever requester issued the read.
//
// state | meaning
// IDLE  | waiting for an eligible requester; grant latches the whole command
// ISSUE | presenting latched command/data to the MIG until both are accepted
module ddr_app_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 512,
  parameter int MASK_W    = DATA_W / 8,
  parameter int TAG_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ddr_app_arbiter_if.slave   bus,
  output logic               rd_orphan_err_o
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              cmd_done_q, cmd_done_d;
  logic              wdf_done_q, wdf_done_d;

  logic              tag_q [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd0_q, rd1_q;
  logic              orphan_q;

  logic app_en, wdf_wren, ready0, ready1;
  logic cmd_ok, wdf_ok, pick, sel_cmd;
  logic full, empty, elig0, elig1, push, pop;

  // Every read is a single beat, so the end marker carries no extra information.
  logic unused_rd_end;
  assign unused_rd_end = bus.app_rd_data_end;

  assign full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign empty = (cnt_q == '0);
  assign elig0 = bus.req0_valid & (~bus.req0_cmd | ~full);
  assign elig1 = bus.req1_valid & (~bus.req1_cmd | ~full);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cmd_done_d = cmd_done_q;
    wdf_done_d = wdf_done_q;
    app_en     = 1'b0;
    wdf_wren   = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    cmd_ok     = 1'b0;
    wdf_ok     = 1'b0;
    pick       = 1'b0;
    sel_cmd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          pick       = (elig0 & elig1) ? ~last_q : elig1;
          sel_cmd    = pick ? bus.req1_cmd : bus.req0_cmd;
          gnt_d      = pick;
          last_d     = pick;
          cmd_d      = sel_cmd;
          addr_d     = pick ? bus.req1_addr : bus.req0_addr;
          wdata_d    = pick ? bus.req1_wdata : bus.req0_wdata;
          wmask_d    = pick ? bus.req1_wmask : bus.req0_wmask;
          cmd_done_d = 1'b0;
          // Reads carry no data phase, so it starts out already satisfied.
          wdf_done_d = sel_cmd;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        app_en   = ~cmd_done_q;
        wdf_wren = ~wdf_done_q;
        cmd_ok   = cmd_done_q | (app_en & bus.app_rdy);
        wdf_ok   = wdf_done_q | (wdf_wren & bus.app_wdf_rdy);
        if (cmd_ok & wdf_ok) begin
          ready0     = ~gnt_q;
          ready1     = gnt_q;
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
          state_d    = IDLE;
        end else begin
          cmd_done_d = cmd_ok;
          wdf_done_d = wdf_ok;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cmd_done_q <= cmd_done_d;
      wdf_done_q <= wdf_done_d;
    end
  end

  assign push = app_en & bus.app_rdy & cmd_q;
  assign pop  = bus.app_rd_data_valid & ~empty;

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= gnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd0_q     <= 1'b0;
      rd1_q     <= 1'b0;
      orphan_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (pop) rd_data_q <= bus.app_rd_data;
      rd0_q <= pop & ~tag_q[rd_ptr_q];
      rd1_q <= pop & tag_q[rd_ptr_q];
      if (bus.app_rd_data_valid & empty) orphan_q <= 1'b1;
    end
  end

  assign bus.app_en       = app_en;
  assign bus.app_cmd      = {2'b00, cmd_q};
  assign bus.app_addr     = addr_q;
  assign bus.app_wdf_data = wdata_q;
  assign bus.app_wdf_mask = wmask_q;
  assign bus.app_wdf_wren = wdf_wren;
  assign bus.app_wdf_end  = wdf_wren;
  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.rd0_valid    = rd0_q;
  assign bus.rd1_valid    = rd1_q;
  assign bus.rd_data      = rd_data_q;
  assign rd_orphan_err_o  = orphan_q;
endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Bench for ddr_app_arbiter: directed scenarios with literal expectations, then random traffic,
// all compared each cycle against a transaction-level model (pending command + tag queue).
module tb_ddr_app_arbiter;
  localparam int AW = 28;
  localparam int DW = 512;
  localparam int MW = 64;
  localparam int TD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic orphan;

  ddr_app_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  ddr_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .rd_orphan_err_o(orphan)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: at most one granted command pending, plus an ordered queue of read owners.
  bit m_busy, m_gnt, m_cmd, m_cseen, m_dseen, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  bit tagq[$];
  bit m_rdv0, m_rdv1, m_orphan;
  logic [DW-1:0] m_rdata;
  bit e_rdy0, e_rdy1;

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_cmd = 0; m_cseen = 0; m_dseen = 0; m_last = 1;
    tagq.delete();
    m_rdv0 = 0; m_rdv1 = 0; m_orphan = 0; m_rdata = '0;
    e_rdy0 = 0; e_rdy1 = 0;
  endtask

  task automatic adv();
    bit e_en, e_wren, cacc, dacc, done, full, el0, el1, g, h;
    e_en   = m_busy && !m_cseen;
    e_wren = m_busy && !m_cmd && !m_dseen;
    cacc   = e_en && bus.app_rdy;
    dacc   = e_wren && bus.app_wdf_rdy;
    done   = m_busy && (m_cseen || cacc) && (m_cmd || m_dseen || dacc);
    e_rdy0 = done && !m_gnt;
    e_rdy1 = done && m_gnt;
    chk("app_en", bus.app_en, e_en);
    if (e_en) begin
      chk("app_cmd", bus.app_cmd, {2'b00, m_cmd});
      chk("app_addr", bus.app_addr, m_addr);
    end
    chk("app_wdf_wren", bus.app_wdf_wren, e_wren);
    chk("app_wdf_end", bus.app_wdf_end, e_wren);
    if (e_wren) begin
      chk("app_wdf_data", bus.app_wdf_data, m_wdata);
      chk("app_wdf_mask", bus.app_wdf_mask, m_wmask);
    end
    chk("req0_ready", bus.req0_ready, e_rdy0);
    chk("req1_ready", bus.req1_ready, e_rdy1);
    chk("rd0_valid", bus.rd0_valid, m_rdv0);
    chk("rd1_valid", bus.rd1_valid, m_rdv1);
    if (m_rdv0 || m_rdv1) chk("rd_data", bus.rd_data, m_rdata);
    chk("rd_orphan_err", orphan, m_orphan);
    if (!rst_n) begin
      model_reset();
    end else begin
      full = (tagq.size() == TD);
      el0  = bus.req0_valid && (!bus.req0_cmd || !full);
      el1  = bus.req1_valid && (!bus.req1_cmd || !full);
      m_rdv0 = 0; m_rdv1 = 0;
      if (bus.app_rd_data_valid) begin
        if (tagq.size() > 0) begin
          h = tagq.pop_front();
          if (h) m_rdv1 = 1; else m_rdv0 = 1;
          m_rdata = bus.app_rd_data;
        end else m_orphan = 1;
      end
      if (cacc && m_cmd) tagq.push_back(m_gnt);
      if (m_busy) begin
        m_cseen = m_cseen | cacc;
        m_dseen = m_dseen | dacc;
        if (done) m_busy = 0;
      end else if (el0 || el1) begin
        g = (el0 && el1) ? !m_last : el1;
        m_busy = 1; m_gnt = g; m_last = g; m_cseen = 0;
        m_cmd   = g ? bus.req1_cmd : bus.req0_cmd;
        m_addr  = g ? bus.req1_addr : bus.req0_addr;
        m_wdata = g ? bus.req1_wdata : bus.req0_wdata;
        m_wmask = g ? bus.req1_wmask : bus.req0_wmask;
        m_dseen = m_cmd;
      end
    end
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int n, input bit v, input bit c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_cmd = c; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_wmask = m;
    end else begin
      bus.req1_valid = v; bus.req1_cmd = c; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_wmask = m;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng, got;
    bit gseq[4];
    bit hold0, hold1;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    bus.app_rdy = 0; bus.app_wdf_rdy = 0; bus.app_rd_data = '0;
    bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0;
    model_reset();
    @(negedge clk);
    cyc();
    settle();
    chk("reset_app_en", bus.app_en, 0);
    chk("reset_wren", bus.app_wdf_wren, 0);
    chk("reset_ready0", bus.req0_ready, 0);
    chk("reset_orphan", orphan, 0);
    adv();
    rst_n = 1;
    cyc();

    // Single write
    set_req(0, 1, 0, 28'h00000EA, 512'd3333, '0);
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    cyc();
    settle();
    chk("sw_app_en", bus.app_en, 1);
    chk("sw_wren", bus.app_wdf_wren, 1);
    chk("sw_end", bus.app_wdf_end, 1);
    chk("sw_cmd", bus.app_cmd, 3'b000);
    chk("sw_addr", bus.app_addr, 28'h00000EA);
    chk("sw_data", bus.app_wdf_data, 512'd3333);
    chk("sw_ready0", bus.req0_ready, 1);
    adv();
    bus.req0_valid = 0;
    settle();
    chk("sw_idle_en", bus.app_en, 0);
    adv();

    // Split accept
    set_req(1, 1, 0, 28'h0000123, 512'h5555, 64'hF0);
    bus.app_wdf_rdy = 0;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) bus.app_wdf_rdy = 1;
      settle();
      chk("split_app_en", bus.app_en, k == 1);
      chk("split_wren", bus.app_wdf_wren, 1);
      chk("split_ready1", bus.req1_ready, k == 4);
      adv();
    end
    bus.req1_valid = 0;
    cyc();

    // Round robin on reads
    set_req(0, 1, 1, 28'h100, '0, '0);
    set_req(1, 1, 1, 28'h200, '0, '0);
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      bit r0, r1;
      settle();
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      if (r0 && ng < 4) gseq[ng++] = 0;
      if (r1 && ng < 4) gseq[ng++] = 1;
      adv();
      if (r0) bus.req0_addr = bus.req0_addr + 28'h10;
      if (r1) bus.req1_addr = bus.req1_addr + 28'h10;
      if (ng == 4) begin bus.req0_valid = 0; bus.req1_valid = 0; end
    end
    chk("rr_grants", ng, 4);
    chk("rr_g0", gseq[0], 0);
    chk("rr_g1", gseq[1], 1);
    chk("rr_g2", gseq[2], 0);
    chk("rr_g3", gseq[3], 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    for (int i = 0; i <= 4; i++) begin
      bus.app_rd_data_valid = (i < 4);
      bus.app_rd_data = 512'hA0 + 512'(i);
      settle();
      chk("rr_rd0", bus.rd0_valid, i > 0 && ((i - 1) % 2 == 0));
      chk("rr_rd1", bus.rd1_valid, i > 0 && ((i - 1) % 2 == 1));
      if (i > 0) chk("rr_rdata", bus.rd_data, 512'hA0 + 512'(i - 1));
      adv();
    end
    bus.app_rd_data_valid = 0;

    // Tag FIFO full
    set_req(0, 1, 1, 28'h4000, '0, '0);
    ng = 0;
    for (int c = 0; c < 100 && ng < TD; c++) begin
      bit r0;
      settle();
      r0 = bus.req0_ready;
      if (r0) ng++;
      adv();
      if (r0) bus.req0_addr = bus.req0_addr + 28'h1;
    end
    chk("full_reads", ng, TD);
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("full_stall_ready0", bus.req0_ready, 0);
      chk("full_stall_en", bus.app_en, 0);
      adv();
    end
    set_req(1, 1, 0, 28'h777, 512'h1234, '0);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      settle();
      if (bus.req1_ready) got = 1;
      adv();
    end
    chk("full_write_granted", got, 1);
    bus.req1_valid = 0;
    bus.app_rd_data_valid = 1; bus.app_rd_data = 512'hBEEF;
    cyc();
    bus.app_rd_data_valid = 0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      settle();
      if (bus.req0_ready) got = 1;
      adv();
    end
    chk("full_unstall", got, 1);
    bus.req0_valid = 0;
    for (int i = 0; i < TD; i++) begin
      bus.app_rd_data_valid = 1; bus.app_rd_data = rnd_data();
      cyc();
    end
    bus.app_rd_data_valid = 0;
    cyc();
    settle();
    chk("drain_no_orphan", orphan, 0);
    adv();

    // Orphan beat
    bus.app_rd_data_valid = 1; bus.app_rd_data = 512'hDEAD;
    cyc();
    bus.app_rd_data_valid = 0;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("orph_rd0", bus.rd0_valid, 0);
      chk("orph_rd1", bus.rd1_valid, 0);
      chk("orph_sticky", orphan, 1);
      adv();
    end

    // Reset while a write is stuck in ISSUE
    bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    set_req(0, 1, 0, 28'h55, 512'h99, '0);
    cyc();
    settle();
    chk("rst_pre_en", bus.app_en, 1);
    rst_n = 0;
    #1;
    chk("rst_async_en", bus.app_en, 0);
    chk("rst_async_wren", bus.app_wdf_wren, 0);
    chk("rst_async_orphan", orphan, 0);
    chk("rst_async_ready0", bus.req0_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    set_req(0, 1, 1, 28'h300, '0, '0);
    set_req(1, 1, 1, 28'h400, '0, '0);
    cyc();
    settle();
    chk("rst_tie_ready0", bus.req0_ready, 1);
    chk("rst_tie_ready1", bus.req1_ready, 0);
    adv();
    bus.req0_valid = 0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      settle();
      if (bus.req1_ready) got = 1;
      adv();
    end
    chk("rst_second_ready1", got, 1);
    bus.req1_valid = 0;

    // Random traffic
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (e_rdy0) hold0 = 0;
      if (e_rdy1) hold1 = 0;
      if (!hold0 && $urandom_range(2) == 0) begin
        hold0 = 1;
        set_req(0, 1, 1'($urandom), AW'($urandom), rnd_data(), {$urandom, $urandom});
      end
      if (!hold1 && $urandom_range(2) == 0) begin
        hold1 = 1;
        set_req(1, 1, 1'($urandom), AW'($urandom), rnd_data(), {$urandom, $urandom});
      end
      bus.req0_valid = hold0;
      bus.req1_valid = hold1;
      bus.app_rdy = ($urandom_range(3) != 0);
      bus.app_wdf_rdy = ($urandom_range(3) != 0);
      bus.app_rd_data_valid = (tagq.size() > 0 && $urandom_range(2) == 0) || ($urandom_range(499) == 0);
      bus.app_rd_data = rnd_data();
      bus.app_rd_data_end = bus.app_rd_data_valid;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
